// File: rtl/mon_capture_fifo.sv
// mon_capture_fifo: capture buffer in front of the monitor UART transmitter.
// Stores 18-bit snoop samples, presents the head over uart_req/uart_ack and
// counts samples dropped on overflow.
// Optional build macro MON_OVF_MARK_EN: after a drop, write the marker word
// 18'h3FFFF into the first free slot so the receiver sees where data was lost.
module mon_capture_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_en,
  input  logic                  cap_vld,
  input  logic [17:0]           cap_dat,
  input  logic                  flush,
  output logic                  uart_req,
  input  logic                  uart_ack,
  output logic [17:0]           uart_dat,
  output logic [DEPTH_LOG2:0]   fifo_cnt,
  output logic                  ovf_flg,
  output logic [7:0]            ovf_cnt
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned DW    = 18;
  localparam logic [DW-1:0]         MARK_WORD = 18'h3FFFF;
  localparam logic [DEPTH_LOG2-1:0] PTR_INC   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_INC   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   FULL_CNT  = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr_nxt;
  logic [DEPTH_LOG2:0]   cnt_nxt;
  logic [DW-1:0]         wr_dat;
  logic [DW-1:0]         head_nxt;
  logic                  pop;
  logic                  room;
  logic                  smp;
  logic                  push;
  logic                  drop;
  logic                  mark_wr;

`ifdef MON_OVF_MARK_EN
  logic                  mark_pend;
`endif

  // Push/pop/drop decode and next-state of occupancy and head word
  always_comb begin
    pop  = uart_ack & (fifo_cnt != '0);
    room = (fifo_cnt != FULL_CNT) | pop;
    smp  = cap_en & cap_vld;
`ifdef MON_OVF_MARK_EN
    mark_wr = room & mark_pend;
`else
    mark_wr = 1'b0;
`endif
    // a marker write takes the free slot, so a sample in that cycle is lost
    push   = mark_wr | (smp & room);
    drop   = smp & (~room | mark_wr);
    wr_dat = mark_wr ? MARK_WORD : cap_dat;

    rd_ptr_nxt = pop ? (rd_ptr + PTR_INC) : rd_ptr;

    case ({push, pop})
      2'b10:   cnt_nxt = fifo_cnt + CNT_INC;
      2'b01:   cnt_nxt = fifo_cnt - CNT_INC;
      default: cnt_nxt = fifo_cnt;
    endcase

    // wr_ptr can only meet the next read slot when the entry being written
    // becomes the head (push into empty, or push+pop leaving one entry)
    if (cnt_nxt == '0) begin
      head_nxt = '0;
    end else if (push && (wr_ptr == rd_ptr_nxt)) begin
      head_nxt = wr_dat;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  // Sample storage, not reset
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointers, occupancy, registered head/request and overflow accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      uart_req <= 1'b0;
      uart_dat <= '0;
      ovf_flg  <= 1'b0;
      ovf_cnt  <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      uart_req <= 1'b0;
      uart_dat <= '0;
      ovf_flg  <= 1'b0;
      ovf_cnt  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_INC;
      end
      rd_ptr   <= rd_ptr_nxt;
      fifo_cnt <= cnt_nxt;
      uart_req <= (cnt_nxt != '0);
      uart_dat <= head_nxt;
      if (drop) begin
        ovf_flg <= 1'b1;
        if (ovf_cnt != 8'hFF) begin
          ovf_cnt <= ovf_cnt + 8'd1;
        end
      end
    end
  end

`ifdef MON_OVF_MARK_EN
  // Pending-marker flag: armed by a drop, cleared once the marker is stored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mark_pend <= 1'b0;
    end else if (flush || mark_wr) begin
      mark_pend <= 1'b0;
    end else if (drop) begin
      mark_pend <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mon_capture_fifo.sv
// tb_mon_capture_fifo: table-driven check of mon_capture_fifo (depth 4) with a
// queue scoreboard for delivered data. Honours MON_OVF_MARK_EN if defined.
module tb_mon_capture_fifo;

  localparam int unsigned DL    = 2;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cap_en, cap_vld, flush, uart_ack;
  logic [17:0] cap_dat;
  logic        uart_req;
  logic [17:0] uart_dat;
  logic [DL:0] fifo_cnt;
  logic        ovf_flg;
  logic [7:0]  ovf_cnt;

  mon_capture_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .cap_vld(cap_vld),
    .cap_dat(cap_dat), .flush(flush), .uart_req(uart_req),
    .uart_ack(uart_ack), .uart_dat(uart_dat), .fifo_cnt(fifo_cnt),
    .ovf_flg(ovf_flg), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        vld;
    logic [17:0] dat;
    logic        ack;
    logic        fl;
    int          cnt;
    logic        req;
    logic        flg;
    int          oc;
  } vec_t;

  vec_t        vecs[$];
  logic [17:0] sb[$];
  logic        mk_pend;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic en, input logic vld, input logic [17:0] dat,
                     input logic ack, input logic fl, input int cnt,
                     input logic req, input logic flg, input int oc);
    vec_t v;
    v.en = en; v.vld = vld; v.dat = dat; v.ack = ack; v.fl = fl;
    v.cnt = cnt; v.req = req; v.flg = flg; v.oc = oc;
    vecs.push_back(v);
  endtask

  // Apply one cycle of inputs, update the scoreboard, then check the head word
  task automatic cyc(input logic en, input logic vld, input logic [17:0] dat,
                     input logic ack, input logic fl);
    logic pop, room;
    logic [17:0] hd;
    if (ack && sb.size() != 0) chk("ack_dat", 32'(uart_dat), 32'(sb[0]));
    cap_en = en; cap_vld = vld; cap_dat = dat; uart_ack = ack; flush = fl;
    pop  = ack && (sb.size() != 0);
    room = (sb.size() < DEPTH) || pop;
    if (fl) begin
      sb.delete();
      mk_pend = 1'b0;
    end else begin
      if (pop) void'(sb.pop_front());
`ifdef MON_OVF_MARK_EN
      if (room && mk_pend) begin
        sb.push_back(18'h3FFFF);
        mk_pend = 1'b0;
      end else if (en && vld && room) begin
        sb.push_back(dat);
      end else if (en && vld) begin
        mk_pend = 1'b1;
      end
`else
      if (en && vld && room) sb.push_back(dat);
`endif
    end
    @(posedge clk);
    #1;
    cap_en = 1'b0; cap_vld = 1'b0; cap_dat = '0; uart_ack = 1'b0; flush = 1'b0;
    hd = (sb.size() != 0) ? sb[0] : 18'h0;
    chk("head_dat", 32'(uart_dat), 32'(hd));
  endtask

  initial begin
    rst = 1'b1;
    cap_en = 1'b0; cap_vld = 1'b0; cap_dat = '0; uart_ack = 1'b0; flush = 1'b0;
    mk_pend = 1'b0;
    #1;
    chk("rst_req", 32'(uart_req), 32'd0);
    chk("rst_dat", 32'(uart_dat), 32'd0);
    chk("rst_cnt", 32'(fifo_cnt), 32'd0);
    chk("rst_flg", 32'(ovf_flg), 32'd0);
    chk("rst_oc",  32'(ovf_cnt), 32'd0);
    #11 rst = 1'b0;
    @(posedge clk); #1;

    // 1: single sample, then ack
    add(1, 1, 18'h1_2345, 0, 0, 1, 1, 0, 0);
    add(0, 0, 18'h0,      1, 0, 0, 0, 0, 0);
    // 2: order and wrap with interleaved acks
    add(1, 1, 18'h0_000A, 0, 0, 1, 1, 0, 0);
    add(1, 1, 18'h1_000B, 0, 0, 2, 1, 0, 0);
    add(1, 1, 18'h2_000C, 1, 0, 2, 1, 0, 0);
    add(1, 1, 18'h3_000D, 0, 0, 3, 1, 0, 0);
    add(1, 1, 18'h0_000E, 1, 0, 3, 1, 0, 0);
    add(1, 1, 18'h1_000F, 0, 0, 4, 1, 0, 0);
    add(0, 0, 18'h0,      1, 0, 3, 1, 0, 0);
    add(0, 0, 18'h0,      1, 0, 2, 1, 0, 0);
    add(0, 0, 18'h0,      1, 0, 1, 1, 0, 0);
    add(0, 0, 18'h0,      1, 0, 0, 0, 0, 0);
    // 3: overflow, six pushes with no ack, then drain
    add(1, 1, 18'h0_1111, 0, 0, 1, 1, 0, 0);
    add(1, 1, 18'h1_2222, 0, 0, 2, 1, 0, 0);
    add(1, 1, 18'h2_3333, 0, 0, 3, 1, 0, 0);
    add(1, 1, 18'h3_4444, 0, 0, 4, 1, 0, 0);
    add(1, 1, 18'h0_5555, 0, 0, 4, 1, 1, 1);
    add(1, 1, 18'h0_6666, 0, 0, 4, 1, 1, 2);
`ifdef MON_OVF_MARK_EN
    add(0, 0, 18'h0,      1, 0, 4, 1, 1, 2);
`endif
    add(0, 0, 18'h0,      1, 0, 3, 1, 1, 2);
    add(0, 0, 18'h0,      1, 0, 2, 1, 1, 2);
    add(0, 0, 18'h0,      1, 0, 1, 1, 1, 2);
    add(0, 0, 18'h0,      1, 0, 0, 0, 1, 2);
    // 5: spurious ack, capture disabled, flush with transfer in flight, late ack
    add(0, 0, 18'h0,      1, 0, 0, 0, 1, 2);
    add(0, 1, 18'h2_BEEF, 0, 0, 0, 0, 1, 2);
    add(1, 1, 18'h0_0001, 0, 0, 1, 1, 1, 2);
    add(1, 1, 18'h0_0002, 0, 0, 2, 1, 1, 2);
    add(1, 1, 18'h0_0003, 0, 0, 3, 1, 1, 2);
    add(1, 1, 18'h0_0004, 0, 1, 0, 0, 0, 0);
    add(0, 0, 18'h0,      1, 0, 0, 0, 0, 0);
    // 4: full, push and ack together
    add(1, 1, 18'h1_0001, 0, 0, 1, 1, 0, 0);
    add(1, 1, 18'h1_0002, 0, 0, 2, 1, 0, 0);
    add(1, 1, 18'h1_0003, 0, 0, 3, 1, 0, 0);
    add(1, 1, 18'h1_0004, 0, 0, 4, 1, 0, 0);
    add(1, 1, 18'h1_0005, 1, 0, 4, 1, 0, 0);
    add(0, 0, 18'h0,      1, 0, 3, 1, 0, 0);
    add(0, 0, 18'h0,      1, 0, 2, 1, 0, 0);
    add(0, 0, 18'h0,      1, 0, 1, 1, 0, 0);
    add(0, 0, 18'h0,      1, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].en, vecs[i].vld, vecs[i].dat, vecs[i].ack, vecs[i].fl);
      chk($sformatf("v%0d_cnt", i), 32'(fifo_cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_req", i), 32'(uart_req), 32'(vecs[i].req));
      chk($sformatf("v%0d_flg", i), 32'(ovf_flg),  32'(vecs[i].flg));
      chk($sformatf("v%0d_oc",  i), 32'(ovf_cnt),  32'(vecs[i].oc));
    end

    // 6: reset mid-operation with entries and ovf_cnt=5
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 18'(32'h2_0100 + i), 1'b0, 1'b0);
    chk("pre_oc5", 32'(ovf_cnt), 32'd5);
    cyc(1'b0, 1'b0, 18'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 18'h0, 1'b1, 1'b0);
    chk("pre_req", 32'(uart_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", 32'(uart_req), 32'd0);
    chk("arst_dat", 32'(uart_dat), 32'd0);
    chk("arst_cnt", 32'(fifo_cnt), 32'd0);
    chk("arst_flg", 32'(ovf_flg), 32'd0);
    chk("arst_oc",  32'(ovf_cnt), 32'd0);
    sb.delete();
    mk_pend = 1'b0;
    @(posedge clk); #1;
    // ack while held in reset must not revive anything
    uart_ack = 1'b1;
    @(posedge clk); #1;
    uart_ack = 1'b0;
    rst = 1'b0;
    chk("rst_ack_cnt", 32'(fifo_cnt), 32'd0);
    cyc(1'b1, 1'b1, 18'h0_00AA, 1'b0, 1'b0);
    chk("post_req", 32'(uart_req), 32'd1);
    chk("post_cnt", 32'(fifo_cnt), 32'd1);
    cyc(1'b0, 1'b0, 18'h0, 1'b1, 1'b0);
    chk("post_req0", 32'(uart_req), 32'd0);
    chk("post_cnt0", 32'(fifo_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
